// File: rtl/sigin_prescaler.sv
// sigin_prescaler
//   Frequency-meter input front end: synchronises the raw sigin, detects its
//   rising edges and divides the edge rate by 10^range. Produces a divided
//   square wave (o_sigin), a one-cycle strobe per divided period (o_edge) and
//   a ready flag once a full divided period has been seen.
//   Optional glitch filter: define SIGIN_FILTER_EN to require FILT_LEN
//   consecutive identical synchronised samples before a level is accepted.
module sigin_prescaler #(
    parameter int STAGES   = 2,
    parameter int NRANGE   = 4,
    parameter int RANGE_W  = 2,
    parameter int CNT_W    = 10,
    parameter int FILT_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sigin,
    input  logic [RANGE_W-1:0] range,
    output logic               o_sigin,
    output logic               o_edge,
    output logic               o_ready
);

    // Terminal count per range: range k toggles every 5*10^(k-1) rises.
    typedef logic [NRANGE-1:0][CNT_W-1:0] tc_tab_t;

    function automatic tc_tab_t build_tc();
        tc_tab_t t;
        longint  p;
        t = '0;
        p = 5;
        for (int k = 1; k < NRANGE; k++) begin
            t[k] = CNT_W'(p - 1);
            p    = p * 10;
        end
        return t;
    endfunction

    localparam tc_tab_t TC = build_tc();
    localparam logic [RANGE_W-1:0] RANGE_MAX = RANGE_W'(NRANGE - 1);

    logic [STAGES-1:0]  sync_q;
    logic               lvl;
    logic               lvl_d;
    logic               rise;
    logic [RANGE_W-1:0] range_c;
    logic [RANGE_W-1:0] range_q;
    logic               range_chg;
    logic [CNT_W-1:0]   tc_sel;
    logic [CNT_W-1:0]   cnt;

    // Metastability synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], sigin};
    end

`ifdef SIGIN_FILTER_EN
    // History of the previous FILT_LEN-1 synchronised samples; together with
    // the current sample it forms the FILT_LEN-long acceptance window.
    logic [FILT_LEN-2:0] filt_hist;
    logic                filt_lvl;
    logic [FILT_LEN-1:0] filt_win;

    assign filt_win = {filt_hist, sync_q[STAGES-1]};

    // Glitch filter: level changes only after a full window of agreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_hist <= '0;
            filt_lvl  <= 1'b0;
        end else begin
            filt_hist <= filt_win[FILT_LEN-2:0];
            if (&filt_win)       filt_lvl <= 1'b1;
            else if (~|filt_win) filt_lvl <= 1'b0;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_q[STAGES-1];
`endif

    // Registered edge detector: rise is a one-cycle strobe per 0->1 of lvl.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
            rise  <= 1'b0;
        end else begin
            lvl_d <= lvl;
            rise  <= lvl & ~lvl_d;
        end
    end

    // Out-of-range selects clamp to the slowest decade.
    always_comb begin
        range_c = (range > RANGE_MAX) ? RANGE_MAX : range;
    end

    assign range_chg = (range_c != range_q);

    // Terminal-count lookup for the active range (entry 0 unused in bypass).
    always_comb begin
        tc_sel = '0;
        for (int k = 0; k < NRANGE; k++) begin
            if (range_q == RANGE_W'(k)) tc_sel = TC[k];
        end
    end

    // Range register; a change restarts the divider on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) range_q <= '0;
        else        range_q <= range_c;
    end

    // Half-period counter: counts rises, clears at terminal count or on a
    // range change (a coincident rise is dropped so no partial count leaks).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       cnt <= '0;
        else if (range_chg)               cnt <= '0;
        else if (range_q != '0 && rise) begin
            if (cnt == tc_sel)            cnt <= '0;
            else                          cnt <= cnt + 1'b1;
        end
    end

    // Divided output and strobe; bypass mirrors the conditioned level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sigin <= 1'b0;
            o_edge  <= 1'b0;
        end else begin
            o_edge <= 1'b0;
            if (range_chg) begin
                o_sigin <= 1'b0;
            end else if (range_q == '0) begin
                o_sigin <= lvl_d;
                o_edge  <= rise;
            end else if (rise && cnt == tc_sel) begin
                o_sigin <= ~o_sigin;
                o_edge  <= ~o_sigin;
            end
        end
    end

    // Ready: latched on the first strobe since reset or the last range change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         o_ready <= 1'b0;
        else if (range_chg) o_ready <= 1'b0;
        else if (range_q == '0) begin
            if (rise)       o_ready <= 1'b1;
        end else if (rise && cnt == tc_sel && !o_sigin) begin
            o_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sigin_prescaler.sv
// Self-checking bench for sigin_prescaler: edge-count reference model,
// vector table, hand-written corner sequences and randomized runs.
module tb_sigin_prescaler;

    localparam int STAGES   = 2;
    localparam int NRANGE   = 4;
    localparam int RANGE_W  = 3;
    localparam int CNT_W    = 10;
    localparam int FILT_LEN = 4;
`ifdef SIGIN_FILTER_EN
    localparam int PMIN = FILT_LEN + 2;
`else
    localparam int PMIN = 2;
`endif
    localparam int PMAX = PMIN + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sigin = 1'b0;
    logic [RANGE_W-1:0] range = '0;
    logic               o_sigin, o_edge, o_ready;

    int   n_chk = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   cur_k = 0;
    logic prev_edge = 1'b0;

    always #5 clk = ~clk;

    sigin_prescaler #(
        .STAGES(STAGES), .NRANGE(NRANGE), .RANGE_W(RANGE_W),
        .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .range(range),
        .o_sigin(o_sigin), .o_edge(o_edge), .o_ready(o_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- reference model: pure edge-count arithmetic ----
    function automatic int eff_k(input int r);
        return (r > NRANGE - 1) ? NRANGE - 1 : r;
    endfunction

    function automatic int half_of(input int k);
        int h = 5;
        for (int i = 1; i < k; i++) h *= 10;
        return h;
    endfunction

    // strobes after n rises: one per 0->1 toggle, toggles every half_of(k)
    function automatic int strobes(input int k, input int n);
        return (k == 0) ? n : (n / half_of(k) + 1) / 2;
    endfunction

    function automatic int level(input int k, input int n);
        return (k == 0) ? 0 : (n / half_of(k)) % 2;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sigin = 1'b1; tick($urandom_range(PMAX, PMIN));
            sigin = 1'b0; tick($urandom_range(PMAX, PMIN));
        end
        tick(4 + STAGES + FILT_LEN);
    endtask

    task automatic do_reset(input logic [RANGE_W-1:0] r);
        rst_n = 1'b0; range = r; sigin = 1'b0; cur_k = eff_k(int'(r));
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    // Strobe monitor: counts o_edge, flags back-to-back strobes when dividing.
    initial begin
        forever begin
            @(negedge clk);
            if (o_edge) begin
                edge_cnt++;
                if (cur_k >= 1) chk("edge_single", int'(prev_edge), 0);
            end
            prev_edge = o_edge;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    typedef struct {
        logic [RANGE_W-1:0] rng;
        int                 nedge;
        int                 exp_edges;
        int                 exp_lvl;
        int                 exp_rdy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   e0, k, n, cnt, r;
        logic hist[64];

        tbl[0] = '{3'd0, 10,   10, 0, 1};
        tbl[1] = '{3'd1, 40,   4,  0, 1};
        tbl[2] = '{3'd1, 7,    1,  1, 1};
        tbl[3] = '{3'd2, 49,   0,  0, 0};
        tbl[4] = '{3'd2, 50,   1,  1, 1};
        tbl[5] = '{3'd3, 499,  0,  0, 0};
        tbl[6] = '{3'd3, 2000, 2,  0, 1};
        tbl[7] = '{3'd6, 500,  1,  1, 1};

        // reset state
        tick(1);
        chk("rst_o_sigin", int'(o_sigin), 0);
        chk("rst_o_edge",  int'(o_edge),  0);
        chk("rst_o_ready", int'(o_ready), 0);

        // vector table
        for (int v = 0; v < 8; v++) begin
            do_reset(tbl[v].rng);
            e0 = edge_cnt;
            pulses(tbl[v].nedge);
            chk($sformatf("vec%0d_edges", v), edge_cnt - e0, tbl[v].exp_edges);
            chk($sformatf("vec%0d_sigin", v), int'(o_sigin), tbl[v].exp_lvl);
            chk($sformatf("vec%0d_ready", v), int'(o_ready), tbl[v].exp_rdy);
        end

`ifndef SIGIN_FILTER_EN
        // bypass: o_sigin is sigin delayed STAGES+2 clocks, one strobe per period
        do_reset(3'd0);
        e0 = edge_cnt;
        for (int i = 0; i < 64; i++) begin
            sigin = ((i % 8) < 4);
            hist[i] = sigin;
            @(negedge clk);
            if (i >= STAGES + 2) chk("bypass_delay", int'(o_sigin), int'(hist[i - (STAGES + 2)]));
            @(posedge clk); #1;
        end
        tick(8);
        chk("bypass_edges", edge_cnt - e0, 8);
        chk("bypass_ready", int'(o_ready), 1);

        // range change 1->2 on the same cycle as a terminal-count rise
        do_reset(3'd1);
        pulses(14);
        chk("pre_chg_ready", int'(o_ready), 1);
        e0 = edge_cnt;
        sigin = 1'b1;
        tick(STAGES + 1);
        range = 3'd2; cur_k = 2;
        tick(3);
        sigin = 1'b0;
        tick(8);
        chk("chg_no_edge", edge_cnt - e0, 0);
        chk("chg_sigin",   int'(o_sigin), 0);
        chk("chg_ready",   int'(o_ready), 0);
        pulses(49);
        chk("chg_discard", edge_cnt - e0, 0);
        pulses(1);
        chk("chg_first",   edge_cnt - e0, 1);
        chk("chg_ready2",  int'(o_ready), 1);
        pulses(100);
        chk("chg_period",  edge_cnt - e0, 2);

        // asynchronous reset mid-period (range 2, c=37 after 87 rises)
        do_reset(3'd2);
        pulses(87);
        chk("pre_rst_sigin", int'(o_sigin), 1);
        chk("pre_rst_ready", int'(o_ready), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_sigin", int'(o_sigin), 0);
        chk("async_edge",  int'(o_edge),  0);
        chk("async_ready", int'(o_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);
        e0 = edge_cnt;
        pulses(49);
        chk("post_rst_none",  edge_cnt - e0, 0);
        pulses(1);
        chk("post_rst_first", edge_cnt - e0, 1);

        // clamp: 3 -> 5 is not a range change, count continues
        do_reset(3'd3);
        e0 = edge_cnt;
        pulses(250);
        range = 3'd5;
        tick(2);
        pulses(250);
        chk("clamp_edges", edge_cnt - e0, 1);
        chk("clamp_sigin", int'(o_sigin), 1);
`else
        // glitch filter: short pulses vanish, long ones count
        do_reset(3'd0);
        e0 = edge_cnt;
        repeat (5) begin
            sigin = 1'b1; tick(FILT_LEN - 1);
            sigin = 1'b0; tick(FILT_LEN + 3);
        end
        tick(12);
        chk("filt_glitch", edge_cnt - e0, 0);
        repeat (5) begin
            sigin = 1'b1; tick(FILT_LEN + 2);
            sigin = 1'b0; tick(FILT_LEN + 2);
        end
        tick(12);
        chk("filt_pulse", edge_cnt - e0, 5);
`endif

        // randomized ranges and edge counts against the model
        do_reset(3'd0);
        k = 0; n = 0;
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(7, 0);
            range = RANGE_W'(r);
            cur_k = eff_k(r);
            if (eff_k(r) != k) begin
                k = eff_k(r);
                n = 0;
            end
            tick(2);
            e0 = edge_cnt;
            cnt = $urandom_range(120, 1);
            pulses(cnt);
            chk($sformatf("rnd%0d_edges", it), edge_cnt - e0, strobes(k, n + cnt) - strobes(k, n));
            n += cnt;
            chk($sformatf("rnd%0d_sigin", it), int'(o_sigin), level(k, n));
            chk($sformatf("rnd%0d_ready", it), int'(o_ready), (strobes(k, n) > 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
